// File: rtl/turn_controller.sv
// Turn sequencing FSM for the card-pick / chicken-move game loop feeding data_path.
// Optional select-phase timeout is compiled in with `define TURN_TIMEOUT_EN.
module turn_controller #(
    parameter int NUM_CARDS      = 12,
    parameter int CARD_W         = 4,
    parameter int REVEAL_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           N,
    input  logic                 card_sel_valid,
    input  logic [CARD_W-1:0]    card_sel,
    input  logic                 go,
    input  logic                 W,
    output logic [CARD_W-1:0]    A,
    output logic                 check_req,
    output logic                 move_en,
    output logic                 statecombo_next_turn,
    output logic [1:0]           cur_player,
    output logic [NUM_CARDS-1:0] card_faceup,
    output logic                 game_over,
    output logic [2:0]           state_o
);

    // Handshake: check_req, move_en and statecombo_next_turn are single-cycle
    // registered pulses; go is valid the cycle after check_req, W the cycle after move_en.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_CHECK  = 3'd2,
        S_RESULT = 3'd3,
        S_MOVE   = 3'd4,
        S_WINCHK = 3'd5,
        S_REVEAL = 3'd6,
        S_OVER   = 3'd7
    } state_t;

    localparam int RCW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [RCW-1:0]  REVEAL_LAST = RCW'(REVEAL_CYCLES - 1);
    localparam logic [CARD_W:0] NUM_CARDS_X = (CARD_W + 1)'(NUM_CARDS);

    state_t               state;
    logic [RCW-1:0]       reveal_cnt;
    logic [NUM_CARDS-1:0] sel_mask;
    logic                 pick_ok;
    logic                 all_up;
    logic [2:0]           n_eff;
    logic [1:0]           last_player;
    logic [1:0]           next_player;
    logic                 turn_end;

`ifdef TURN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timeout_cnt;
`endif

    assign sel_mask = NUM_CARDS'(1) << card_sel;
    assign pick_ok  = card_sel_valid && ({1'b0, card_sel} < NUM_CARDS_X)
                      && ((card_faceup & sel_mask) == '0);
    assign all_up   = &card_faceup;

    // Player count is clamped to 2..4 and only consulted at a turn boundary.
    assign n_eff       = (N < 3'd2) ? 3'd2 : (N > 3'd4) ? 3'd4 : N;
    assign last_player = 2'(n_eff - 3'd1);
    assign next_player = (cur_player >= last_player) ? 2'd0 : cur_player + 2'd1;

    always_comb begin
        turn_end = 1'b0;
        case (state)
            S_WINCHK: turn_end = !W && all_up;
            S_REVEAL: turn_end = (reveal_cnt == REVEAL_LAST);
            default:  turn_end = 1'b0;
        endcase
`ifdef TURN_TIMEOUT_EN
        if (state == S_SELECT && !pick_ok && timeout_cnt == TIMEOUT_LAST)
            turn_end = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            A                    <= '0;
            check_req            <= 1'b0;
            move_en              <= 1'b0;
            statecombo_next_turn <= 1'b0;
            cur_player           <= 2'd0;
            card_faceup          <= '0;
            game_over            <= 1'b0;
            reveal_cnt           <= '0;
`ifdef TURN_TIMEOUT_EN
            timeout_cnt          <= '0;
`endif
        end else begin
            check_req            <= 1'b0;
            move_en              <= 1'b0;
            statecombo_next_turn <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_SELECT;
                        cur_player  <= 2'd0;
                        card_faceup <= '0;
                    end
                end
                S_SELECT: begin
                    if (pick_ok) begin
                        A           <= card_sel;
                        card_faceup <= card_faceup | sel_mask;
                        check_req   <= 1'b1;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: state <= S_RESULT;
                S_RESULT: begin
                    if (go) begin
                        move_en <= 1'b1;
                        state   <= S_MOVE;
                    end else begin
                        reveal_cnt <= '0;
                        state      <= S_REVEAL;
                    end
                end
                S_MOVE: state <= S_WINCHK;
                S_WINCHK: begin
                    if (W) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                S_REVEAL: reveal_cnt <= reveal_cnt + RCW'(1);
                S_OVER: begin
                    if (start) begin
                        game_over <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Turn hand-over overrides whatever transition the case chose.
            if (turn_end) begin
                statecombo_next_turn <= 1'b1;
                card_faceup          <= '0;
                cur_player           <= next_player;
                state                <= S_SELECT;
            end

`ifdef TURN_TIMEOUT_EN
            if (state != S_SELECT || pick_ok || turn_end)
                timeout_cnt <= '0;
            else
                timeout_cnt <= timeout_cnt + TW'(1);
`endif
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_turn_controller.sv
// Table-driven bench for turn_controller: per-cycle vectors plus a card-ID scoreboard on check_req.
module tb_turn_controller;

    localparam int RC = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  N;
    logic        card_sel_valid;
    logic [3:0]  card_sel;
    logic        go;
    logic        W;
    logic [3:0]  A;
    logic        check_req;
    logic        move_en;
    logic        statecombo_next_turn;
    logic [1:0]  cur_player;
    logic [11:0] card_faceup;
    logic        game_over;
    logic [2:0]  state_o;

    turn_controller #(
        .NUM_CARDS(12), .CARD_W(4), .REVEAL_CYCLES(RC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .N(N),
        .card_sel_valid(card_sel_valid), .card_sel(card_sel),
        .go(go), .W(W), .A(A), .check_req(check_req), .move_en(move_en),
        .statecombo_next_turn(statecombo_next_turn), .cur_player(cur_player),
        .card_faceup(card_faceup), .game_over(game_over), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  a;
        logic        cr;
        logic        me;
        logic        nt;
        logic [1:0]  cp;
        logic [11:0] fu;
        logic        gov;
    } obs_t;

    typedef struct packed {
        logic       start;
        logic [2:0] n;
        logic       csv;
        logic [3:0] cs;
        logic       go;
        logic       w;
        obs_t       exp;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    obs_t       e;
    logic [2:0] e_n;

    function automatic obs_t get_obs();
        obs_t o;
        o = {state_o, A, check_req, move_en, statecombo_next_turn, cur_player, card_faceup, game_over};
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d a=%0d cr=%b me=%b nt=%b cp=%0d fu=%03h gov=%b",
                         o.st, o.a, o.cr, o.me, o.nt, o.cp, o.fu, o.gov);
    endfunction

    task automatic check(input obs_t exp, input string name);
        obs_t got;
        got = get_obs();
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] cp, input logic [2:0] n);
        int ne;
        ne = (n < 3'd2) ? 2 : (n > 3'd4) ? 4 : int'(n);
        return (int'(cp) >= ne - 1) ? 2'd0 : cp + 2'd1;
    endfunction

    task automatic push_vec(input logic s, input logic v, input logic [3:0] c,
                            input logic g, input logic w);
        vec_t t;
        t.start = s; t.n = e_n; t.csv = v; t.cs = c; t.go = g; t.w = w; t.exp = e;
        vecs.push_back(t);
        e.cr = 1'b0; e.me = 1'b0; e.nt = 1'b0;
    endtask

    task automatic turn_end_exp();
        e.st = 3'd1; e.nt = 1'b1; e.fu = '0; e.cp = nxt(e.cp, e_n);
    endtask

    task automatic hit(input logic [3:0] c, input logic win);
        e.st = 3'd2; e.a = c; e.cr = 1'b1; e.fu[c] = 1'b1;
        push_vec(1'b0, 1'b1, c, 1'b0, 1'b0);
        e.st = 3'd3;
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        e.st = 3'd4; e.me = 1'b1;
        push_vec(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        e.st = 3'd5;
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        if (win) begin
            e.st = 3'd7; e.gov = 1'b1;
        end else if (&e.fu) begin
            turn_end_exp();
        end else begin
            e.st = 3'd1;
        end
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, win);
    endtask

    task automatic miss(input logic [3:0] c, input logic inject);
        e.st = 3'd2; e.a = c; e.cr = 1'b1; e.fu[c] = 1'b1;
        push_vec(1'b0, 1'b1, c, 1'b0, 1'b0);
        e.st = 3'd3;
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        e.st = 3'd6;
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 1; k < RC; k++) begin
            if (inject && k == 1)
                push_vec(1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
            else
                push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        turn_end_exp();
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic bad(input logic [3:0] c);
        push_vec(1'b0, 1'b1, c, 1'b0, 1'b0);
    endtask

    task automatic apply(input vec_t v, input string name);
        start = v.start; N = v.n; card_sel_valid = v.csv; card_sel = v.cs; go = v.go; W = v.w;
        if (v.csv && v.exp.st == 3'd2) exp_q.push_back(v.cs);
        @(posedge clk);
        @(negedge clk);
        check(v.exp, name);
    endtask

    // Every check_req must present the card most recently accepted.
    always @(negedge clk) begin
        if (rst === 1'b0 && check_req === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_check_req: got A=%0d, expected no check_req", A);
            end else begin
                logic [3:0] exp_a;
                exp_a = exp_q.pop_front();
                if (A !== exp_a) begin
                    n_err++;
                    $display("FAIL sb_card_id: got A=%0d, expected %0d", A, exp_a);
                end
            end
        end
    end

    initial begin
        obs_t zero;
        zero = '0;
        rst = 1'b1; start = 1'b0; N = 3'd3; card_sel_valid = 1'b0;
        card_sel = 4'd0; go = 1'b0; W = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(zero, "reset_state");
        rst = 1'b0;

        e = '0; e_n = 3'd3;
        e.st = 3'd1;
        push_vec(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        hit(4'd5, 1'b0);
        bad(4'd5); bad(4'd12); bad(4'd15);
        miss(4'd7, 1'b1);
        miss(4'd0, 1'b0);
        miss(4'd11, 1'b0);
        e_n = 3'd1; miss(4'd2, 1'b0);
        e_n = 3'd7; miss(4'd3, 1'b0);
        e_n = 3'd2; miss(4'd4, 1'b0);
        e_n = 3'd3;
        for (int c = 0; c < 12; c++) hit(4'(c), 1'b0);
        hit(4'd6, 1'b1);
        push_vec(1'b0, 1'b1, 4'd8, 1'b1, 1'b1);
        e.st = 3'd0; e.gov = 1'b0;
        push_vec(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        e.st = 3'd1; e.cp = 2'd0; e.fu = '0;
        push_vec(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

        // Reset while a mismatched card is still showing.
        vecs.delete();
        e.st = 3'd2; e.a = 4'd9; e.cr = 1'b1; e.fu[9] = 1'b1;
        push_vec(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        e.st = 3'd3;
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        e.st = 3'd6;
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        push_vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        foreach (vecs[i]) apply(vecs[i], $sformatf("prereset_row%0d", i));
        rst = 1'b1; card_sel_valid = 1'b0; go = 1'b0; W = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(zero, "reset_mid_reveal");
        rst = 1'b0;

`ifdef TURN_TIMEOUT_EN
        begin
            int  cyc;
            bool_t_dummy: ;
        end
`endif
`ifdef TURN_TIMEOUT_EN
        begin
            int   cyc;
            logic seen_me;
            logic seen_nt;
            obs_t te;
            te = '0; te.st = 3'd1;
            start = 1'b1; N = 3'd3;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check(te, "timeout_start");
            cyc = 0; seen_me = 1'b0; seen_nt = 1'b0;
            while (!seen_nt && cyc < 200) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (move_en) seen_me = 1'b1;
                if (statecombo_next_turn) seen_nt = 1'b1;
            end
            n_cmp++;
            if (!seen_nt || cyc != TO) begin
                n_err++;
                $display("FAIL timeout_cycles: got nt=%b after %0d cycles, expected pulse after %0d", seen_nt, cyc, TO);
            end
            n_cmp++;
            if (seen_me !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_no_move: got move_en=%b, expected 0", seen_me);
            end
            n_cmp++;
            if (cur_player !== 2'd1 || state_o !== 3'd1) begin
                n_err++;
                $display("FAIL timeout_pass: got cp=%0d st=%0d, expected cp=1 st=1", cur_player, state_o);
            end
        end
`endif

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending picks, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Game-sequencing FSM directly upstream of data_path in the ChickenCHACHACHA FPGA design.
- Accepts player card picks and presents the latched card ID on `A`.
- Requests a match check, consumes `go`/`W` from data_path, and generates the `statecombo_next_turn` pulse consumed by data_path's turn logic.
- Tracks face-up cards within a turn, the reveal delay after a miss, the current player and game over.

Parameters:
- NUM_CARDS, 12, number of face-down picture cards (at most 16).
- CARD_W, 4, width of the card index / `A` bus.
- REVEAL_CYCLES, 16, cycles a mismatched card stays face-up before the turn passes.
- TIMEOUT_CYCLES, 64, select-phase timeout; used only with TURN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a game from IDLE, returns OVER to IDLE.
- N  in  3  number of players; values below 2 treated as 2, above 4 treated as 4.
- card_sel_valid  in  1  one-cycle strobe: player picks card_sel.
- card_sel  in  CARD_W  picked card index.
- go  in  1  match result from data_path; valid the cycle after check_req.
- W  in  1  win flag from data_path; valid the cycle after move_en.
- A  out  CARD_W  latched picked card ID, driven to data_path.
- check_req  out  1  one-cycle pulse requesting a match check of A.
- move_en  out  1  one-cycle pulse: advance the current chicken one tile.
- statecombo_next_turn  out  1  one-cycle pulse: turn passes to the next player.
- cur_player  out  2  index of the active player, 0..N-1.
- card_faceup  out  NUM_CARDS  bitmask of cards currently shown.
- game_over  out  1  high in OVER.
- state_o  out  3  current FSM state encoding, for debug/LED.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge, in any state, including mid-reveal) sets:
  - state IDLE; A=0; cur_player=0; card_faceup=0;
  - all pulses 0; game_over=0; counters 0.
- State encodings: IDLE=0, SELECT=1, CHECK=2, RESULT=3, MOVE=4, WINCHK=5, REVEAL=6, OVER=7.
- IDLE:
  - start → SELECT; cur_player=0, card_faceup=0.
- SELECT:
  - Accept card_sel_valid only if card_sel<NUM_CARDS and card_faceup[card_sel]==0.
  - On accept: A<=card_sel, set card_faceup[card_sel], → CHECK.
  - Invalid or already-face-up picks are ignored; state and outputs are unchanged.
- CHECK:
  - check_req=1 for exactly this cycle.
  - → RESULT.
- RESULT:
  - Sample go.
  - go=1 → MOVE.
  - go=0 → REVEAL with the counter cleared.
- MOVE:
  - move_en=1 for this cycle.
  - → WINCHK.
- WINCHK:
  - Sample W.
  - W=1 → OVER.
  - Else, if every card bit is set → turn end; else → SELECT (same player continues).
- REVEAL:
  - Counter increments each cycle.
  - When counter==REVEAL_CYCLES-1 → turn end.
  - The mismatched card stays face-up for exactly REVEAL_CYCLES cycles.
- Turn end (single cycle, same edge):
  - statecombo_next_turn=1;
  - card_faceup<=0;
  - cur_player<=(cur_player==Neff-1)?0:cur_player+1;
  - → SELECT.
- OVER:
  - game_over=1; cur_player and card_faceup hold.
  - start → IDLE. All other inputs are ignored.
- Latency:
  - pick → check_req: 1 cycle;
  - check_req → go sampled: 1 cycle;
  - successful pick → move_en: 3 cycles.
- Simultaneous events:
  - card_sel_valid outside SELECT is ignored.
  - start outside IDLE/OVER is ignored.
  - rst has priority over all.
- If N changes mid-game, Neff re-evaluates at the next turn end.
  - If cur_player>=Neff at that point, it wraps to 0.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - A counter runs while in SELECT and clears on each accepted pick or on entry to SELECT.
  - Reaching TIMEOUT_CYCLES forfeits the turn: turn-end actions, no move_en.
- Undefined:
  - SELECT waits indefinitely.
  - No timeout counter logic is synthesized.

Test Plan:
- rst, then start with N=3 → next cycle state_o=1, cur_player=0, card_faceup=0; no pulses.
- Pick card 5 with go=1, W=0 →
  - check_req 1 cycle after the pick;
  - move_en 3 cycles after the pick;
  - card_faceup=0x020; back in SELECT with cur_player=0.
- Pick card 7 with go=0, REVEAL_CYCLES=4 →
  - card 7 face-up for 4 cycles;
  - then statecombo_next_turn pulses once, card_faceup=0, cur_player=1.
- Invalid picks → no check_req:
  - re-pick of a face-up card;
  - card_sel=12 with NUM_CARDS=12.
- Rotation: with N=3, three consecutive misses → cur_player 0→1→2→0.
- Game over and reset:
  - go=1 then W=1 → game_over=1, state_o=7; start → IDLE.
  - rst asserted mid-REVEAL → all outputs at their reset values next cycle.
- With TURN_TIMEOUT_EN, TIMEOUT_CYCLES=64: no pick for 64 cycles → statecombo_next_turn pulses, move_en stays 0.
